// File: rtl/seg_display_arbiter.sv
// Arbitrates one 8-digit multiplexed seven-segment display among three clients.
// Fixed priority (bit 0 highest); a minimum hold time delays preemption.
module seg_display_arbiter #(
   parameter int unsigned SCAN_DIV    = 100_000,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [7:0]  blank0,
   input  logic [7:0]  blank1,
   input  logic [7:0]  blank2,
   output logic [2:0]  grant,
   output logic [7:0]  AN,
   output logic        CA,
   output logic        CB,
   output logic        CC,
   output logic        CD,
   output logic        CE,
   output logic        CF,
   output logic        CG,
   output logic        DP
);

   localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [DivW-1:0]  DivMax  = DivW'(SCAN_DIV - 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

   state_e           r_state;
   logic [1:0]       r_owner;
   logic [2:0]       r_grant;
   logic [HoldW-1:0] r_hold_cnt;
   logic [DivW-1:0]  r_div;
   logic [2:0]       r_idx;
   logic [7:0]       r_an;
   logic [6:0]       r_cat;

   logic [1:0]  w_pick;
   logic [2:0]  w_pick_oh;
   logic        w_own_req;
   logic        w_higher;
   logic        w_expired;
   logic [31:0] w_data;
   logic [7:0]  w_blank;
   logic [3:0]  w_nib;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Lowest set request index wins arbitration.
   always_comb begin
      w_pick    = 2'd2;
      w_pick_oh = 3'b100;
      if (req[0]) begin
         w_pick    = 2'd0;
         w_pick_oh = 3'b001;
      end else if (req[1]) begin
         w_pick    = 2'd1;
         w_pick_oh = 3'b010;
      end
   end

   always_comb begin
      w_own_req = 1'b0;
      w_higher  = 1'b0;
      w_data    = 32'h0;
      w_blank   = 8'hFF;
      case (r_owner)
         2'd0: begin
            w_own_req = req[0];
            w_data    = data0;
            w_blank   = blank0;
         end
         2'd1: begin
            w_own_req = req[1];
            w_higher  = req[0];
            w_data    = data1;
            w_blank   = blank1;
         end
         2'd2: begin
            w_own_req = req[2];
            w_higher  = |req[1:0];
            w_data    = data2;
            w_blank   = blank2;
         end
         default: begin
            w_own_req = 1'b0;
         end
      endcase
   end

   assign w_expired = (r_hold_cnt == HoldMax);
   assign w_nib     = w_data[{r_idx, 2'b00} +: 4];

   // Ownership FSM; the hold only gates preemption, never release.
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         r_state    <= StIdle;
         r_owner    <= 2'd0;
         r_grant    <= 3'b000;
         r_hold_cnt <= '0;
      end else begin
         case (r_state)
            StIdle, StGap: begin
               r_hold_cnt <= '0;
               if (req != 3'b000) begin
                  r_state <= StOwn;
                  r_owner <= w_pick;
                  r_grant <= w_pick_oh;
               end else begin
                  r_state <= StIdle;
                  r_grant <= 3'b000;
               end
            end
            StOwn: begin
               if (!w_own_req || (w_expired && w_higher)) begin
                  r_state <= StGap;
                  r_grant <= 3'b000;
               end
               if (!w_expired) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_grant <= 3'b000;
            end
         endcase
      end
   end

   // Free-running digit scan.
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= 3'd0;
      end else if (r_div == DivMax) begin
         r_div <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         r_an  <= 8'hFF;
         r_cat <= 7'h7F;
      end else if ((r_state == StOwn) && !w_blank[r_idx]) begin
         r_an  <= ~(8'h01 << r_idx);
         r_cat <= ~seg_decode(w_nib);
      end else begin
         r_an  <= 8'hFF;
         r_cat <= 7'h7F;
      end
   end

   assign grant = r_grant;
   assign AN    = r_an;
   assign CA    = r_cat[0];
   assign CB    = r_cat[1];
   assign CC    = r_cat[2];
   assign CD    = r_cat[3];
   assign CE    = r_cat[4];
   assign CF    = r_cat[5];
   assign CG    = r_cat[6];
   assign DP    = 1'b1;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against an
// ownership/scan reference model.
module tb_seg_display_arbiter;

   localparam int SD = 4;
   localparam int HC = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [31:0] data [3];
   logic [7:0]  blank [3];
   logic [2:0]  grant;
   logic [7:0]  an;
   logic        ca, cb, cc, cd, ce, cf, cg, dp;

   int n_checks = 0;
   int n_errors = 0;

   int         m_own  = -1;
   int         m_held = 0;
   int         m_tick = 0;
   logic [7:0] m_an   = 8'hFF;
   logic [6:0] m_cat  = 7'h7F;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_CYCLES(HC)) dut (
      .CLK100MHZ(clk), .rst(rst), .req(req),
      .data0(data[0]), .data1(data[1]), .data2(data[2]),
      .blank0(blank[0]), .blank1(blank[1]), .blank2(blank[2]),
      .grant(grant), .AN(an),
      .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg), .DP(dp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [2:0] r);
      for (int i = 0; i < 3; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic logic [2:0] m_grant();
      return (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
   endfunction

   function automatic int m_idx();
      return (m_tick / SD) % 8;
   endfunction

   // Advance the reference by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int idx;
      int nib;
      if (rst) begin
         m_own  = -1;
         m_held = 0;
         m_tick = 0;
         m_an   = 8'hFF;
         m_cat  = 7'h7F;
      end else begin
         idx = m_idx();
         if (m_own >= 0 && !blank[m_own][idx]) begin
            nib   = int'((data[m_own] >> (4 * idx)) & 32'hF);
            m_an  = ~(8'h01 << idx);
            m_cat = ~seg_tab[nib];
         end else begin
            m_an  = 8'hFF;
            m_cat = 7'h7F;
         end
         if (m_own < 0) begin
            m_own  = lowest(req);
            m_held = 0;
         end else if (!req[m_own] ||
                      (m_held >= HC - 1 && (int'(req) & ((1 << m_own) - 1)) != 0)) begin
            m_own = -1;
         end else begin
            m_held++;
         end
         m_tick++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("grant", 32'(grant), 32'(m_grant()));
      check_eq("an", 32'(an), 32'(m_an));
      check_eq("cat", 32'({cg, cf, ce, cd, cc, cb, ca}), 32'(m_cat));
      check_eq("dp", 32'(dp), 32'd1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         req = 3'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;
      req = 3'b000;
   endtask

   task automatic wait_held(input int target, input int own);
      int k;
      for (k = 0; k < 50; k++) begin
         if (m_own == own && m_held == target) break;
         step();
      end
      if (k == 50) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_held got=timeout exp=held%0d", target);
      end
   endtask

   initial begin
      int low_hi;
      for (int k = 0; k < 3; k++) begin
         data[k]  = 32'h0;
         blank[k] = 8'h00;
      end
      data[0] = 32'h7654_3210;
      data[1] = 32'hFEDC_BA98;

      // Reset with random requests.
      do_reset(3);
      rst = 1'b1;
      step();
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_an", 32'(an), 32'hFF);
      check_eq("rst_cat", 32'({cg, cf, ce, cd, cc, cb, ca}), 32'h7F);
      rst = 1'b0;

      // Single owner.
      data[2]  = 32'h0000_0A1E;
      blank[2] = 8'hF0;
      req      = 3'b100;
      step();
      check_eq("single_grant", 32'(grant), 32'b100);
      low_hi = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (an[7:4] != 4'hF) low_hi++;
         if (an == 8'hFE) check_eq("digit_e", 32'({cg, cf, ce, cd, cc, cb, ca}), 32'h06);
      end
      check_eq("an_hi_dark", 32'(low_hi), 32'd0);

      // Hold, then preemption by client 0.
      do_reset(1);
      req = 3'b100;
      wait_held(3, 2);
      req = 3'b101;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("hold_grant", 32'(grant), 32'b100);
      end
      step();
      check_eq("preempt_gap", 32'(grant), 32'b000);
      step();
      check_eq("preempt_new", 32'(grant), 32'b001);
      for (int i = 0; i < 16; i++) step();

      // Release to another client, then to nobody.
      do_reset(1);
      req = 3'b010;
      wait_held(2, 1);
      req = 3'b100;
      step();
      check_eq("rel_gap", 32'(grant), 32'b000);
      step();
      check_eq("rel_new", 32'(grant), 32'b100);
      req = 3'b000;
      step();
      check_eq("rel_idle", 32'(grant), 32'b000);
      step();
      step();
      check_eq("rel_idle_an", 32'(an), 32'hFF);

      // Simultaneous requests.
      do_reset(1);
      req = 3'b111;
      step();
      check_eq("simul_grant", 32'(grant), 32'b001);
      req = 3'b110;
      step();
      check_eq("simul_gap", 32'(grant), 32'b000);
      step();
      check_eq("simul_next", 32'(grant), 32'b010);

      // Reset mid-operation.
      do_reset(1);
      req = 3'b001;
      for (int i = 0; i < 40 && !(m_own == 0 && m_idx() == 5); i++) step();
      check_eq("mid_idx5", 32'(m_idx()), 32'd5);
      rst = 1'b1;
      step();
      check_eq("mid_rst_grant", 32'(grant), 32'b000);
      check_eq("mid_rst_an", 32'(an), 32'hFF);
      rst = 1'b0;
      step();
      check_eq("mid_regrant", 32'(grant), 32'b001);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 15) == 0) data[k] = $urandom;
            if ($urandom_range(0, 31) == 0)
               blank[k] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
